bus_mem_slave: RTL and testbench
================================

# bus_mem_slave

Single-port main-memory slave on the shared cache/memory bus, directly downstream of the bus interconnect. It accepts one word-wide read or write per transaction from the bus slave port and returns a one-cycle ready pulse after a fixed, parameterised access latency. This models the off-chip memory that cache line fills and write-backs target.

## Interface
- BUS_DATA_WIDTH, 64, bus word width (one cache-line beat).
- BUS_ADR_WIDTH, 14, bus word address width.
- MEM_ADR_WIDTH, 10, implemented depth is 2^MEM_ADR_WIDTH words; must be ≤ BUS_ADR_WIDTH.
- LATENCY, 4, cycles from request acceptance to ready; legal range 1..15.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- s_bus_address  in  BUS_ADR_WIDTH  word address from the bus.
- s_bus_datain  in  BUS_DATA_WIDTH  write data from the bus.
- s_bus_dataout  out  BUS_DATA_WIDTH  read data to the bus.
- s_bus_rd  in  1  read request level.
- s_bus_wr  in  1  write request level.
- s_bus_ready  out  1  transaction-complete pulse.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: if s_bus_wr or s_bus_rd is high at a rising edge, the request is accepted on that edge.
  - Address and operation are latched.
  - A write commits s_bus_datain to mem[address[MEM_ADR_WIDTH-1:0]] on the accept edge.
  - If LATENCY=1, the FSM goes to DONE; otherwise it goes to BUSY with wait counter = LATENCY-1.
- BUSY: the counter decrements each cycle. When the counter reaches 1, the FSM moves to DONE on the next edge.
- DONE:
  - s_bus_ready=1 for exactly this one cycle.
  - For a read, s_bus_dataout holds the word read from the latched address.
  - The FSM always returns to IDLE on the next edge.
- Read data is captured into the dataout register on the edge entering DONE. It is held unchanged until the next read completes. Writes do not change dataout.
- s_bus_rd and s_bus_wr both high at accept: the transaction is treated as a write.
- Address bits above MEM_ADR_WIDTH are ignored (aliasing).
- Inputs are not sampled in BUSY or DONE. Request changes mid-transaction have no effect.
- Protocol: the master holds rd/wr, address and data stable until it sees ready, then drops the request in the following cycle.
  - A request still high in the IDLE cycle after DONE is accepted as a new transaction, so back-to-back accesses are legal.
- Reset (any time, including mid-transaction):
  - State goes to IDLE, counter to 0, s_bus_ready to 0, s_bus_dataout to 0.
  - Memory contents are not cleared.
  - A write already accepted stays committed.
  - No ready is issued for the aborted transaction.

## Timing
- Accept edge = edge E0, at the end of the IDLE cycle where the request is seen.
- s_bus_ready is high during cycle E0+LATENCY only (LATENCY edges after E0). Read data is valid in the same cycle.
- Minimum request-to-request spacing: LATENCY+1 cycles.
- A write is visible to a read accepted at or after E0+1.
- Outputs come directly from flops; there is no combinational path from inputs to outputs.

## Structure
- Shared package bus_pkg holds:
  - BUS_DATA_WIDTH and BUS_ADR_WIDTH defaults, shared with the interconnect and the cache controller;
  - the FSM state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2);
  - the latency counter width (4 bits).
- Sub-module sp_ram: single-port synchronous RAM.
  - Parameters: data width and address width.
  - Ports: clk, we, addr, din, dout.
  - One-cycle registered read.
  - The FSM issues the read address one cycle before entering DONE so dout lands on time. For LATENCY=1 the read address is driven combinationally from s_bus_address in IDLE.

## Test plan
- Reset while idle: after reset release, s_bus_ready=0 and s_bus_dataout=64'h0. With no requests for 20 cycles, ready stays 0.
- Write then read (LATENCY=4): write addr 14'h0012, data 64'hDEAD_BEEF_0123_4567 → ready pulses in cycle E0+4. Then read 14'h0012 → ready at its E0+4 with dataout=64'hDEAD_BEEF_0123_4567, held afterwards.
- Back-to-back (LATENCY=1): keep rd high continuously over addresses 0,1,2 holding 64'h1,64'h2,64'h3 → ready every second cycle with data 1,2,3 in order.
- Aliasing and priority (MEM_ADR_WIDTH=10): rd=wr=1 at addr 14'h0405, data 64'hAA → treated as a write. Then read 14'h0005 → 64'hAA.
- Reset mid-read (LATENCY=8): assert rst at E0+3 → ready never pulses, dataout=0. A later read of the same address returns the previously written value.
- Request change in BUSY: read 14'h0001, then switch to wr at 14'h0002 during BUSY → data at 14'h0002 unchanged, and the returned data is mem[1].

Source files
------------

// File: rtl/bus_pkg.sv
// Shared bus definitions for the cache/memory bus.
// Holds the default bus word and address widths, used by the interconnect,
// the cache controller and the memory slave. Also holds the slave FSM state
// encoding and the width of the access-latency counter.
package bus_pkg;

    localparam int BUS_DATA_WIDTH = 64;
    localparam int BUS_ADR_WIDTH  = 14;
    localparam int CNT_WIDTH      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } bus_state_t;

endpackage

// File: rtl/sp_ram.sv
// Single-port synchronous RAM with a one-cycle registered read.
// The read is read-first: a write and a read of the same address on the
// same edge return the old contents. The array has no reset.
// Ports:
//   clk   rising-edge clock
//   we    write enable; din is stored at addr on the rising edge
//   addr  word address, used for both the write and the read
//   din   write data
//   dout  registered read data, mem[addr] as sampled at the last edge
module sp_ram #(
    parameter int DATA_WIDTH = 64,
    parameter int ADR_WIDTH  = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADR_WIDTH-1:0]  addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mem [2**ADR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
        dout <= mem[addr];
    end

endmodule

// File: rtl/bus_mem_slave.sv
// Main-memory slave on the shared cache/memory bus.
// The slave accepts one word read or write per transaction. It returns a
// one-cycle ready pulse LATENCY cycles after the accept edge. A write lands
// in memory on the accept edge. Read data is valid in the ready cycle and
// is held until the next read completes.
// State table:
//   IDLE | waiting for s_bus_rd / s_bus_wr; inputs are sampled only here
//   BUSY | latency countdown; the RAM read address is held at the latched address
//   DONE | s_bus_ready high for one cycle; read data is on s_bus_dataout
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-high reset
//   s_bus_address  word address (bits above MEM_ADR_WIDTH are ignored)
//   s_bus_datain   write data
//   s_bus_dataout  read data
//   s_bus_rd       read request level
//   s_bus_wr       write request level (takes priority over rd)
//   s_bus_ready    transaction-complete pulse
module bus_mem_slave
    import bus_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = bus_pkg::BUS_DATA_WIDTH,
    parameter int BUS_ADR_WIDTH  = bus_pkg::BUS_ADR_WIDTH,
    parameter int MEM_ADR_WIDTH  = 10,
    parameter int LATENCY        = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [BUS_ADR_WIDTH-1:0]  s_bus_address,
    input  logic [BUS_DATA_WIDTH-1:0] s_bus_datain,
    output logic [BUS_DATA_WIDTH-1:0] s_bus_dataout,
    input  logic                      s_bus_rd,
    input  logic                      s_bus_wr,
    output logic                      s_bus_ready
);

    localparam logic [CNT_WIDTH-1:0] CNT_INIT = CNT_WIDTH'(LATENCY - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    bus_state_t                state;
    logic [CNT_WIDTH-1:0]      cnt;
    logic [MEM_ADR_WIDTH-1:0]  adr_q;
    logic                      op_rd_q;
    logic [BUS_DATA_WIDTH-1:0] dout_q;

    logic                      accept;
    logic                      ram_we;
    logic [MEM_ADR_WIDTH-1:0]  ram_addr;
    logic [BUS_DATA_WIDTH-1:0] ram_dout;

    // The upper address bits alias onto the implemented depth.
    logic unused_adr_bits;
    assign unused_adr_bits = ^s_bus_address;

    assign accept = (state == IDLE) && (s_bus_rd || s_bus_wr);
    assign ram_we = (state == IDLE) && s_bus_wr;

    // In IDLE the live bus address goes to the RAM. For LATENCY=1 this
    // makes the read land on the accept edge, which is also the edge
    // entering DONE. Otherwise the latched address is held through BUSY,
    // so the RAM read taken on the edge entering DONE is always correct.
    assign ram_addr = (state == IDLE) ? s_bus_address[MEM_ADR_WIDTH-1:0] : adr_q;

    sp_ram #(
        .DATA_WIDTH (BUS_DATA_WIDTH),
        .ADR_WIDTH  (MEM_ADR_WIDTH)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (ram_addr),
        .din  (s_bus_datain),
        .dout (ram_dout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            adr_q       <= '0;
            op_rd_q     <= 1'b0;
            dout_q      <= '0;
            s_bus_ready <= 1'b0;
        end else begin
            s_bus_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        adr_q   <= s_bus_address[MEM_ADR_WIDTH-1:0];
                        op_rd_q <= ~s_bus_wr;
                        if (LATENCY == 1) begin
                            state       <= DONE;
                            s_bus_ready <= 1'b1;
                        end else begin
                            state <= BUSY;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                BUSY: begin
                    if (cnt == CNT_ONE) begin
                        state       <= DONE;
                        s_bus_ready <= 1'b1;
                        cnt         <= '0;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    if (op_rd_q) begin
                        dout_q <= ram_dout;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The RAM output register doubles as the dataout register for the ready
    // cycle. dout_q takes over from the next edge, so the value is held
    // while the RAM address moves on. The select comes only from flops, so
    // no input reaches the output combinationally. Reset forces IDLE and
    // clears dout_q, which drives the output to zero.
    assign s_bus_dataout = (state == DONE && op_rd_q) ? ram_dout : dout_q;

endmodule

// File: tb/tb_bus_mem_slave.sv
module tb_bus_mem_slave;

    typedef struct {
        int          dut;
        logic [63:0] data;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int issued = 0;
    int done_cnt = 0;
    logic [63:0] lr [3];

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [13:0] adr  [3];
    logic [63:0] din  [3];
    logic [63:0] dout [3];
    logic        rd   [3];
    logic        wr   [3];
    logic        rdy  [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bus_mem_slave #(.LATENCY(4)) u_l4 (
        .clk(clk), .rst(rst), .s_bus_address(adr[0]), .s_bus_datain(din[0]),
        .s_bus_dataout(dout[0]), .s_bus_rd(rd[0]), .s_bus_wr(wr[0]), .s_bus_ready(rdy[0]));

    bus_mem_slave #(.LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst), .s_bus_address(adr[1]), .s_bus_datain(din[1]),
        .s_bus_dataout(dout[1]), .s_bus_rd(rd[1]), .s_bus_wr(wr[1]), .s_bus_ready(rdy[1]));

    bus_mem_slave #(.LATENCY(8)) u_l8 (
        .clk(clk), .rst(rst), .s_bus_address(adr[2]), .s_bus_datain(din[2]),
        .s_bus_dataout(dout[2]), .s_bus_rd(rd[2]), .s_bus_wr(wr[2]), .s_bus_ready(rdy[2]));

    function automatic int lat_of(input int d);
        case (d)
            0:       return 4;
            1:       return 1;
            default: return 8;
        endcase
    endfunction

    // Monitor: every ready pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                if (rdy[i]) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_ready dut=%0d cyc=%0d got ready=1 want 0", i, cyc);
                    end else begin
                        e = sb.pop_front();
                        total++;
                        if (e.dut != i || e.cyc != cyc) begin
                            bad++;
                            $display("FAIL ready_timing got dut=%0d cyc=%0d want dut=%0d cyc=%0d",
                                     i, cyc, e.dut, e.cyc);
                        end
                        total++;
                        if (dout[i] !== e.data) begin
                            bad++;
                            $display("FAIL ready_data dut=%0d got %h want %h", i, dout[i], e.data);
                        end
                        done_cnt++;
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got %h want %h", name, act, want);
        end
    endtask

    task automatic issue(input int d, input logic r, input logic w, input logic [13:0] a,
                         input logic [63:0] dat, input logic [63:0] want);
        @(posedge clk);
        #1;
        rd[d]  = r;
        wr[d]  = w;
        adr[d] = a;
        din[d] = dat;
        sb.push_back('{d, want, cyc + lat_of(d)});
        issued++;
    endtask

    task automatic wait_done();
        int n = 0;
        while (done_cnt < issued && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (done_cnt < issued) begin
            total++;
            bad++;
            $display("FAIL ready_timeout got done=%0d want %0d", done_cnt, issued);
            sb.delete();
            done_cnt = issued;
        end
    endtask

    // A write returns the last read data, so the model tracks it per DUT.
    task automatic txn(input int d, input logic r, input logic w, input logic [13:0] a,
                       input logic [63:0] dat, input logic [63:0] rd_want);
        logic [63:0] want;
        if (w) begin
            want = lr[d];
        end else begin
            want  = rd_want;
            lr[d] = rd_want;
        end
        issue(d, r, w, a, dat, want);
        wait_done();
    endtask

    task automatic drop(input int d);
        @(posedge clk);
        #1;
        rd[d] = 1'b0;
        wr[d] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            adr[i] = '0;
            din[i] = '0;
            rd[i]  = 1'b0;
            wr[i]  = 1'b0;
            lr[i]  = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Idle after reset: no ready for 20 cycles, and dataout is zero.
        repeat (20) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check("reset_ready", {63'd0, rdy[i]}, 64'd0);
            check("reset_dataout", dout[i], 64'h0);
        end

        // LATENCY=4: write, then read back, then check that the data is held.
        txn(0, 1'b0, 1'b1, 14'h0012, 64'hDEAD_BEEF_0123_4567, '0);
        drop(0);
        txn(0, 1'b1, 1'b0, 14'h0012, 64'h0, 64'hDEAD_BEEF_0123_4567);
        drop(0);
        repeat (3) @(posedge clk);
        #1;
        check("read_held", dout[0], 64'hDEAD_BEEF_0123_4567);

        // LATENCY=1: back-to-back writes, then a continuous read burst.
        txn(1, 1'b0, 1'b1, 14'h0000, 64'h1, '0);
        txn(1, 1'b0, 1'b1, 14'h0001, 64'h2, '0);
        txn(1, 1'b0, 1'b1, 14'h0002, 64'h3, '0);
        drop(1);
        txn(1, 1'b1, 1'b0, 14'h0000, 64'h0, 64'h1);
        txn(1, 1'b1, 1'b0, 14'h0001, 64'h0, 64'h2);
        txn(1, 1'b1, 1'b0, 14'h0002, 64'h0, 64'h3);
        drop(1);

        // rd and wr both high means a write; the high address bits alias.
        txn(0, 1'b1, 1'b1, 14'h0405, 64'hAA, '0);
        drop(0);
        txn(0, 1'b1, 1'b0, 14'h0005, 64'h0, 64'hAA);
        drop(0);

        // LATENCY=8: reset in the middle of a read.
        txn(2, 1'b0, 1'b1, 14'h0033, 64'h5555_0000_CAFE_F00D, '0);
        drop(2);
        @(posedge clk);
        #1;
        rd[2]  = 1'b1;
        adr[2] = 14'h0033;
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        rst   = 1'b1;
        rd[2] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) lr[i] = '0;
        repeat (12) @(posedge clk);
        #1;
        check("abort_dataout", dout[2], 64'h0);
        check("abort_dataout_l4", dout[0], 64'h0);
        txn(2, 1'b1, 1'b0, 14'h0033, 64'h0, 64'h5555_0000_CAFE_F00D);
        drop(2);

        // Requests that change in BUSY are ignored.
        txn(0, 1'b0, 1'b1, 14'h0001, 64'h1111, '0);
        drop(0);
        txn(0, 1'b0, 1'b1, 14'h0002, 64'h2222, '0);
        drop(0);
        lr[0] = 64'h1111;
        issue(0, 1'b1, 1'b0, 14'h0001, 64'h0, 64'h1111);
        @(posedge clk);
        @(posedge clk);
        #1;
        rd[0]  = 1'b0;
        wr[0]  = 1'b1;
        adr[0] = 14'h0002;
        din[0] = 64'h9999;
        wait_done();
        drop(0);
        txn(0, 1'b1, 1'b0, 14'h0002, 64'h0, 64'h2222);
        drop(0);

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
